line_in_recorder: RTL

- Capture side of the codec path. Records line-in audio from the adau1761_codec into an internal sample RAM, then plays it back on request.
- Playback output has the same sample_out / new_sample_generated format the music player drives into hphone_l.
- Sits between the codec's line_in_l / new_sample outputs and the headphone sample mux in the top level.
- Record and play controls are single-cycle pulses from button_press_unit instances.

---
 rtl/line_in_recorder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/line_in_recorder.sv
// Line-in recorder: captures codec left-channel frames into a sample RAM and
// replays them in the same sample_out/new_sample_generated format as the music player.
module line_in_recorder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_button,
  input  logic                  play_button,
  input  logic                  new_frame,
  input  logic [23:0]           line_in,
  output logic [15:0]           sample_out,
  output logic                  new_sample_generated,
  output logic                  recording,
  output logic                  playing,
  output logic [ADDR_WIDTH:0]   length
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           ram_q;
  logic                  silent;
  logic                  do_write;
  logic                  do_read;
  logic                  emit;
  logic                  wr_last;
  logic                  rd_last;
  logic                  unused_lsbs;

  assign unused_lsbs = ^line_in[7:0];

  // A stop press in the same cycle as a frame wins: that frame is neither stored nor read.
  assign do_write = (state == RECORD) && new_frame && !record_button;
  assign do_read  = (state == PLAY) && new_frame && !play_button;
  assign emit     = new_frame && !((state == PLAY) && play_button);
  assign wr_last  = &wr_addr;
  assign rd_last  = ({1'b0, rd_addr} + 1'b1) == length;
  assign ram_addr = (state == RECORD) ? wr_addr : rd_addr;

  // NOTE: the sample RAM has no reset so it maps onto block RAM; its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[ram_addr] <= line_in[23:8];
    end else if (do_read) begin
      ram_q <= mem[ram_addr];
    end
  end

  // ram_q only moves on a played frame, and silent only on a pulse, so the output holds between pulses.
  assign sample_out = silent ? '0 : ram_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      wr_addr              <= '0;
      rd_addr              <= '0;
      length               <= '0;
      recording            <= 1'b0;
      playing              <= 1'b0;
      new_sample_generated <= 1'b0;
      silent               <= 1'b1;
    end else begin
      new_sample_generated <= emit;
      if (emit) begin
        silent <= !do_read;
      end

      case (state)
        IDLE: begin
          if (record_button) begin
            state     <= RECORD;
            recording <= 1'b1;
            wr_addr   <= '0;
            length    <= '0;
          end else if (play_button && (length != '0)) begin
            state   <= PLAY;
            playing <= 1'b1;
            rd_addr <= '0;
          end
        end

        RECORD: begin
          if (record_button) begin
            state     <= IDLE;
            recording <= 1'b0;
          end else if (new_frame) begin
            length <= length + 1'b1;
            if (wr_last) begin
              state     <= IDLE;
              recording <= 1'b0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end

        PLAY: begin
          if (play_button) begin
            state   <= IDLE;
            playing <= 1'b0;
          end else if (new_frame) begin
            if (rd_last) begin
              state   <= IDLE;
              playing <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          recording <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule
